// File: rtl/mult16x16_arbiter.sv
// Round-robin sequencer sharing one pipelined 16x16 multiplier among NREQ requesters.
// Requester IDs ride a tag shift register matched to the multiplier latency.
module mult16x16_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned LAT  = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rstn,
   input  logic [NREQ-1:0]      i_req_valid,
   output logic [NREQ-1:0]      o_req_ready,
   input  logic [16*NREQ-1:0]   i_req_a,
   input  logic [16*NREQ-1:0]   i_req_b,
   input  logic [NREQ-1:0]      i_req_ans,
   input  logic [NREQ-1:0]      i_req_bns,
   output logic [NREQ-1:0]      o_rsp_valid,
   output logic [31:0]          o_rsp_product,
   output logic [15:0]          o_mult_a,
   output logic [15:0]          o_mult_b,
   output logic                 o_multa_ns,
   output logic                 o_multb_ns,
   input  logic [31:0]          i_mult_product,
   output logic                 o_busy
);

   localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IDW-1:0]  ptr_q;
   logic [IDW-1:0]  cand;
   logic [IDW-1:0]  gnt_idx;
   logic            gnt_found;
   logic [NREQ-1:0] grant;
   logic [15:0]     sel_a;
   logic [15:0]     sel_b;
   logic            sel_ans;
   logic            sel_bns;

   logic [LAT:0]    tag_v_q;
   logic [IDW-1:0]  tag_id_q [LAT+1];

   // Search starts just after the last granted requester, wrapping at NREQ.
   always_comb begin
      cand      = '0;
      gnt_idx   = '0;
      gnt_found = 1'b0;
      for (int unsigned off = 1; off <= NREQ; off++) begin
         cand = IDW'((32'(ptr_q) + off) % NREQ);
         if (!gnt_found && i_req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   assign grant       = gnt_found ? (NREQ'(1) << gnt_idx) : '0;
   assign o_req_ready = grant & {NREQ{i_rstn}};

   always_comb begin
      sel_a   = '0;
      sel_b   = '0;
      sel_ans = 1'b0;
      sel_bns = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (grant[k]) begin
            sel_a   = i_req_a[16*k +: 16];
            sel_b   = i_req_b[16*k +: 16];
            sel_ans = i_req_ans[k];
            sel_bns = i_req_bns[k];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         ptr_q         <= IDW'(NREQ - 1);
         o_mult_a      <= '0;
         o_mult_b      <= '0;
         o_multa_ns    <= 1'b0;
         o_multb_ns    <= 1'b0;
         tag_v_q       <= '0;
         for (int unsigned i = 0; i <= LAT; i++) begin
            tag_id_q[i] <= '0;
         end
         o_rsp_valid   <= '0;
         o_rsp_product <= '0;
      end else begin
         if (gnt_found) begin
            ptr_q      <= gnt_idx;
            o_mult_a   <= sel_a;
            o_mult_b   <= sel_b;
            o_multa_ns <= sel_ans;
            o_multb_ns <= sel_bns;
         end
         tag_v_q[0]  <= gnt_found;
         tag_id_q[0] <= gnt_idx;
         for (int unsigned i = 1; i <= LAT; i++) begin
            tag_v_q[i]  <= tag_v_q[i-1];
            tag_id_q[i] <= tag_id_q[i-1];
         end
         // Last tag stage lines up with the product on i_mult_product.
         if (tag_v_q[LAT]) begin
            o_rsp_product <= i_mult_product;
            o_rsp_valid   <= NREQ'(1) << tag_id_q[LAT];
         end else begin
            o_rsp_valid   <= '0;
         end
      end
   end

   assign o_busy = |tag_v_q;

endmodule
